// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the SRAM-backed memory stage.
package mem_stage_sram_pkg;

   localparam int unsigned WAIT_CYCLES_DEF = 4;
   localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
   localparam int unsigned SRAM_AW         = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// SRAM access sequencer: FSM, wait counter and registered SRAM pins.
module sram_ctrl
   import mem_stage_sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req,
   input  logic               wr_req,
   input  logic [SRAM_AW-1:0] addr,
   input  logic [31:0]        wdata,
   input  logic [31:0]        sram_rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   output logic               sram_we_n,
   output logic [31:0]        mem_data
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] cnt;
   logic       load_op;
   logic       req;
   logic       take;
   logic       last;

   assign req = rd_req | wr_req;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode plus ready and the accept/finish strobes.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      take       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            ready = ~req;
            if (req) begin
               take       = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset behaves as IDLE so the pipeline is not frozen while it is held.
      if (rst) ready = ~req;
   end

   // Wait counter, SRAM pin registers and load-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         load_op    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_we_n  <= 1'b1;
         mem_data   <= '0;
      end else begin
         if (take) begin
            cnt        <= '0;
            load_op    <= rd_req & ~wr_req;
            sram_addr  <= addr;
            sram_wdata <= wdata;
            sram_we_n  <= ~wr_req;
         end
         if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
            if (last) begin
               sram_we_n <= 1'b1;
               if (load_op) mem_data <= sram_rdata;
            end
         end
      end
   end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage over a multi-cycle SRAM: address mapping, pass-throughs, ready gating.
module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        ALU_res_in,
   input  logic [31:0]        Val_Rm_in,
   input  logic               Mem_R_EN_in,
   input  logic               Mem_W_EN_in,
   input  logic               WB_EN_in,
   input  logic [3:0]         dest_in,
   output logic [31:0]        ALU_res,
   output logic [3:0]         dest,
   output logic               WB_EN,
   output logic               Mem_R_EN,
   output logic [31:0]        Mem_Data,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_addr,
   output logic [31:0]        SRAM_wdata,
   input  logic [31:0]        SRAM_rdata,
   output logic               SRAM_WE_N
);

   logic [SRAM_AW-1:0] word_addr;

   // Byte address relative to the SRAM base, modulo 2^32, as a word index.
   assign word_addr = SRAM_AW'((ALU_res_in - BASE_ADDR) >> 2);

   assign ALU_res  = ALU_res_in;
   assign dest     = dest_in;
   assign WB_EN    = WB_EN_in & ready;
   assign Mem_R_EN = Mem_R_EN_in & ready;

   sram_ctrl #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .rd_req     (Mem_R_EN_in),
      .wr_req     (Mem_W_EN_in),
      .addr       (word_addr),
      .wdata      (Val_Rm_in),
      .sram_rdata (SRAM_rdata),
      .ready      (ready),
      .sram_addr  (SRAM_addr),
      .sram_wdata (SRAM_wdata),
      .sram_we_n  (SRAM_WE_N),
      .mem_data   (Mem_Data)
   );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: random pipeline traffic against a memory reference model.
module tb_mem_stage_sram;

   localparam int unsigned W    = 4;
   localparam logic [31:0] BASE = 32'd1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] alu_in, rm_in;
   logic        r_in, w_in, wb_in;
   logic [3:0]  d_in;
   logic [31:0] alu_out, mem_data, sram_wdata, sram_rdata;
   logic [3:0]  d_out;
   logic        wb_out, mr_out, ready, we_n;
   logic [15:0] sram_addr;

   logic [31:0] alu_b, rm_b;
   logic        r_b, w_b, wb_b;
   logic [31:0] alu_out_b, mem_data_b, sram_wdata_b, sram_rdata_b;
   logic [3:0]  d_out_b;
   logic        wb_out_b, mr_out_b, ready_b, we_n_b;
   logic [15:0] sram_addr_b;

   mem_stage_sram u_dut (
      .clk(clk), .rst(rst), .ALU_res_in(alu_in), .Val_Rm_in(rm_in),
      .Mem_R_EN_in(r_in), .Mem_W_EN_in(w_in), .WB_EN_in(wb_in), .dest_in(d_in),
      .ALU_res(alu_out), .dest(d_out), .WB_EN(wb_out), .Mem_R_EN(mr_out),
      .Mem_Data(mem_data), .ready(ready), .SRAM_addr(sram_addr),
      .SRAM_wdata(sram_wdata), .SRAM_rdata(sram_rdata), .SRAM_WE_N(we_n)
   );

   mem_stage_sram #(.WAIT_CYCLES(1)) u_dut_b (
      .clk(clk), .rst(rst), .ALU_res_in(alu_b), .Val_Rm_in(rm_b),
      .Mem_R_EN_in(r_b), .Mem_W_EN_in(w_b), .WB_EN_in(wb_b), .dest_in(4'd0),
      .ALU_res(alu_out_b), .dest(d_out_b), .WB_EN(wb_out_b), .Mem_R_EN(mr_out_b),
      .Mem_Data(mem_data_b), .ready(ready_b), .SRAM_addr(sram_addr_b),
      .SRAM_wdata(sram_wdata_b), .SRAM_rdata(sram_rdata_b), .SRAM_WE_N(we_n_b)
   );

   // SRAM environment models.
   logic [31:0] sram_mem   [0:65535];
   logic [31:0] sram_mem_b [0:65535];
   assign sram_rdata   = sram_mem[sram_addr];
   assign sram_rdata_b = sram_mem_b[sram_addr_b];
   always @(posedge clk) if (we_n === 1'b0) sram_mem[sram_addr] <= sram_wdata;
   always @(posedge clk) if (we_n_b === 1'b0) sram_mem_b[sram_addr_b] <= sram_wdata_b;

   typedef struct {
      int unsigned cycles;
      int unsigned we_cycles;
      logic [31:0] mdata;
      logic [15:0] addr;
      logic        wb;
      logic        mr;
      logic [31:0] alu;
      logic [3:0]  dest;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [int unsigned];
   logic [31:0] last_load;
   logic [15:0] last_addr;
   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;
   int unsigned cyc, wec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_up();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   endtask

   // Reference model: expected outcome of one instruction from the stage's rules.
   task automatic issue(input logic [31:0] a, input logic [31:0] v, input logic r,
                        input logic w, input logic wb, input logic [3:0] d);
      exp_t        e;
      int unsigned word;
      int          n;
      word = ((a - BASE) >> 2) & 32'h0000_FFFF;
      if (r | w) last_addr = word[15:0];
      if (w) model_mem[word] = v;
      else if (r) last_load = model_mem.exists(word) ? model_mem[word] : 32'h0;
      e.cycles    = (r | w) ? W + 2 : 1;
      e.we_cycles = w ? W : 0;
      e.mdata     = last_load;
      e.addr      = last_addr;
      e.wb        = wb;
      e.mr        = r;
      e.alu       = a;
      e.dest      = d;
      exp_q.push_back(e);
      alu_in = a; rm_in = v; r_in = r; w_in = w; wb_in = wb; d_in = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < 40);
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_timeout: got %b expected 1 within 40 cycles", ready);
         finish_up();
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: retire one expected instruction on every ready cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!mon_en) begin
         cyc = 0;
         wec = 0;
      end else begin
         cyc++;
         if (we_n === 1'b0) wec++;
         if (ready !== 1'b1) begin
            chk("stall_wb_en", 32'(wb_out), 32'd0);
            chk("stall_mem_r_en", 32'(mr_out), 32'd0);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("cycles", cyc, e.cycles);
            chk("we_n_low_cycles", wec, e.we_cycles);
            chk("mem_data", mem_data, e.mdata);
            chk("sram_addr", 32'(sram_addr), 32'(e.addr));
            chk("wb_en", 32'(wb_out), 32'(e.wb));
            chk("mem_r_en", 32'(mr_out), 32'(e.mr));
            chk("alu_res", alu_out, e.alu);
            chk("dest", 32'(d_out), 32'(e.dest));
            cyc = 0;
            wec = 0;
         end
      end
   end

   initial begin
      logic [31:0] a, v, val_b;
      int          pulses, p0, p1, kind;
      bit          was_ready;

      rst = 1'b1;
      alu_in = '0; rm_in = '0; r_in = 0; w_in = 0; wb_in = 0; d_in = '0;
      alu_b  = '0; rm_b  = '0; r_b  = 0; w_b  = 0; wb_b  = 0;
      last_load = '0;
      last_addr = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("ready_in_reset", 32'(ready), 32'd1);
      chk("ready_b_in_reset", 32'(ready_b), 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_sram_wdata", sram_wdata, 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;

      // Directed scenarios followed by random traffic.
      mon_en = 1'b1;
      issue(32'd1028, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 4'd0);
      issue(32'd1028, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5);
      issue(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3);
      issue(32'd0, $urandom, 1'b1, 1'b1, 1'b1, 4'd7);
      for (int k = 0; k < 8; k++) issue(BASE + 32'(4 * k), $urandom, 1'b0, 1'b1, 1'b0, 4'd1);
      for (int i = 0; i < 150; i++) begin
         kind = int'($urandom_range(0, 9));
         a    = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         v    = $urandom;
         case (kind)
            0, 1, 2: issue(a, v, 1'b1, 1'b0, 1'($urandom), 4'($urandom));
            3, 4, 5: issue(a, v, 1'b0, 1'b1, 1'($urandom), 4'($urandom));
            6:       issue($urandom, v, 1'b0, 1'b1, 1'b0, 4'($urandom));
            7:       issue(a, v, 1'b1, 1'b1, 1'($urandom), 4'($urandom));
            default: issue($urandom, v, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
         endcase
      end
      mon_en = 1'b0;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // Back-to-back store then load on the single-wait-cycle instance.
      val_b = $urandom;
      alu_b = 32'd1024; rm_b = val_b; w_b = 1'b1; r_b = 1'b0; wb_b = 1'b0;
      pulses = 0; p0 = -1; p1 = -1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         was_ready = (ready_b === 1'b1);
         if (was_ready) begin
            pulses++;
            if (p0 < 0) p0 = i; else p1 = i;
            if (i == 5) chk("b2b_load_wb_en", 32'(wb_out_b), 32'd1);
         end
         @(posedge clk); #1;
         if (was_ready && pulses == 1) begin
            w_b = 1'b0; r_b = 1'b1; wb_b = 1'b1;
         end else if (was_ready) begin
            r_b = 1'b0; wb_b = 1'b0;
         end
      end
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk("b2b_store_done", 32'(p0), 32'd2);
      chk("b2b_load_done", 32'(p1), 32'd5);
      chk("b2b_load_data", mem_data_b, val_b);

      // Reset on the second ACCESS cycle of a store.
      a = BASE + 32'(4 * $urandom_range(0, 7));
      v = $urandom;
      model_mem[((a - BASE) >> 2) & 32'h0000_FFFF] = v;
      alu_in = a; rm_in = v; r_in = 1'b0; w_in = 1'b1; wb_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_access_we_n", 32'(we_n), 32'd0);
      chk("mid_access_ready", 32'(ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      w_in = 1'b0;
      @(negedge clk);
      chk("abort_we_n", 32'(we_n), 32'd1);
      chk("abort_mem_data", mem_data, 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_sram_addr", 32'(sram_addr), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      last_load = '0;
      last_addr = '0;

      mon_en = 1'b1;
      issue(a, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2);
      for (int i = 0; i < 20; i++) begin
         a = BASE + 32'(4 * $urandom_range(0, 7));
         issue(a, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      end
      mon_en = 1'b0;
      chk("queue_drained_end", 32'(exp_q.size()), 32'd0);
      finish_up();
   end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: SRAM access cycles per load/store, legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ALU_res_in  in  32  byte address (loads/stores), or ALU result passed through.
REQ-006 Val_Rm_in  in  32  store data.
REQ-007 Mem_R_EN_in / Mem_W_EN_in / WB_EN_in  in  1 each  load request / store request / writeback enable.
REQ-008 dest_in  in  4  destination register.
REQ-009 ALU_res  out  32 / dest  out  4: combinational copies of ALU_res_in / dest_in.
REQ-010 WB_EN, Mem_R_EN  out  1: WB_EN_in & ready, Mem_R_EN_in & ready.
REQ-011 Mem_Data  out  32  registered load data, feeds the MEM/WB register.
REQ-012 ready  out  1  high = stage completes this cycle; freeze = ~ready to PC/IF/ID/EXE registers.
REQ-013 SRAM_addr  out  16  registered word address.
REQ-014 SRAM_wdata  out  32  registered write data; SRAM_rdata  in  32  read data, valid from the 2nd access cycle onward.
REQ-015 SRAM_WE_N  out  1  registered write strobe, active-low.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE, no request: ready=1, SRAM_WE_N=1, all other state held.
REQ-018 IDLE, request (Mem_R_EN_in|Mem_W_EN_in): ready=0; next state ACCESS; wait counter<=0; SRAM_addr<=(ALU_res_in-BASE_ADDR)[17:2]; SRAM_wdata<=Val_Rm_in; SRAM_WE_N<=~Mem_W_EN_in.
REQ-019 Both enables high: treated as store; Mem_Data unchanged.
REQ-020 ACCESS: ready=0; counter increments each cycle; on counter==WAIT_CYCLES-1, next state DONE and SRAM_WE_N<=1.
REQ-021 Load: Mem_Data<=SRAM_rdata on the last ACCESS cycle; Mem_Data otherwise holds its value until the next load.
REQ-022 DONE: ready=1 for exactly one cycle; next state IDLE unconditionally (inputs then belong to the next instruction).
REQ-023 Latency: a load/store occupies WAIT_CYCLES+2 cycles, ready low for the first WAIT_CYCLES+1; non-memory instructions take 1 cycle.
REQ-024 Back-to-back memory ops: the second op's request is sampled in the IDLE cycle after DONE; no request is ever lost or duplicated.
REQ-025 Address arithmetic modulo 2^32; addresses below BASE_ADDR wrap, with no range check; low two bits ignored.
REQ-026 Inputs are ignored during ACCESS/DONE; the upstream register holds them frozen.

Reset
REQ-027 rst high at any clock edge, including mid-ACCESS: state<=IDLE, counter<=0, SRAM_WE_N<=1, SRAM_addr<=0, SRAM_wdata<=0, Mem_Data<=0.
REQ-028 During and after reset with no request: ready=1.
REQ-029 An interrupted store drops its strobe at the reset edge; no retry.

Structure
REQ-030 Shared package holds: FSM state typedef (2-bit encoding), WAIT_CYCLES and BASE_ADDR defaults, SRAM address width 16.
REQ-031 Sub-module sram_ctrl contains the FSM, wait counter and SRAM pin registers; mem_stage_sram contains the address calculation, pass-throughs and ready gating.

Verification
REQ-032 Store: rst release, then ALU_res_in=1028, Val_Rm_in=0xDEADBEEF, Mem_W_EN_in=1 -> SRAM_addr=1, SRAM_WE_N low for exactly 4 cycles, ready low 5 cycles then high 1 cycle.
REQ-033 Load after store: ALU_res_in=1028, Mem_R_EN_in=1, SRAM model returns 0xDEADBEEF -> Mem_Data=0xDEADBEEF; WB_EN=Mem_R_EN=1 only in the DONE cycle.
REQ-034 Non-memory op: WB_EN_in=1, ALU_res_in=0x55, dest_in=3 -> ready=1, outputs pass through in the same cycle, and the FSM stays IDLE.
REQ-035 Reset mid-access: rst asserted on the 2nd ACCESS cycle of a store -> next cycle state IDLE, SRAM_WE_N=1, Mem_Data=0, ready=1.
REQ-036 Back-to-back: store(1024) then load(1024) with WAIT_CYCLES=1 -> each takes 3 cycles, the load returns the stored value, and there are exactly 2 ready pulses.
REQ-037 Wrap and priority: ALU_res_in=0, both enables high -> SRAM_addr=0xFF00, SRAM_WE_N asserted, Mem_Data unchanged.
